// File: rtl/moving_stats_window.sv
// rtl/moving_stats_window.sv - sliding-window mean/variance/stddev engine with internal circular sample store
// Optional o_sqrt_rem port enabled by defining MOVING_STATS_REMAINDER_EN.
module moving_stats_window #(
    parameter int DATA_WIDTH  = 32,
    parameter int LOG2_WINDOW = 6
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_clear,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [DATA_WIDTH-1:0]   i_data,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_mean,
    output logic [2*DATA_WIDTH-1:0] o_variance,
    output logic [DATA_WIDTH-1:0]   o_stddev,
`ifdef MOVING_STATS_REMAINDER_EN
    output logic [2*DATA_WIDTH:0]   o_sqrt_rem,
`endif
    output logic                    o_window_full
);
    localparam int DW = DATA_WIDTH;
    localparam int L  = LOG2_WINDOW;
    localparam int W  = 1 << L;
    localparam int SW = DW + L;
    localparam int QW = 2*DW + L;
    localparam int VW = 2*DW + 2*L;
    localparam int CW = $clog2(DW);
    localparam logic [L:0] FULL = (L+1)'(W);

    typedef enum logic [2:0] {IDLE, ACCUM, VAR, SQRT, DONE} state_t;
    state_t state, state_next;

    logic [DW-1:0]   mem [W];
    logic [DW-1:0]   sample_q;
    logic [L-1:0]    wr_ptr;
    logic [L:0]      fill;
    logic [SW-1:0]   sum;
    logic [QW-1:0]   sumsq;
    logic [DW-1:0]   mean_q;
    logic [2*DW-1:0] var_q;
    logic [CW-1:0]   bit_cnt;
    logic [DW-1:0]   root;
    logic [DW:0]     rem;

    logic [DW-1:0]   outgoing;
    logic [VW-1:0]   var_num;
    logic [1:0]      pair;
    logic [DW+2:0]   rem_shift, trial, rem_next;
    logic            root_bit;

    always_comb begin
        outgoing  = (fill == FULL) ? mem[wr_ptr] : '0;
        // W*sumsq >= sum^2 always (Cauchy-Schwarz), so the subtraction cannot wrap
        var_num   = (VW'(sumsq) << L) - VW'(sum) * VW'(sum);
        pair      = var_q[{bit_cnt, 1'b0} +: 2];
        rem_shift = {rem, pair};
        trial     = {1'b0, root, 2'b01};
        root_bit  = (rem_shift >= trial);
        rem_next  = root_bit ? (rem_shift - trial) : rem_shift;
    end

    always_comb begin
        state_next = state;
        o_ready    = (state == IDLE);
        o_valid    = (state == DONE);
        case (state)
            IDLE:  if (i_valid) state_next = ACCUM;
            ACCUM: state_next = VAR;
            VAR:   state_next = SQRT;
            SQRT:  if (bit_cnt == '0) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (i_clear) state_next = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    // Buffer contents are never reset; fill gates whether a slot is read back.
    always_ff @(posedge i_clk) begin
        if (state == ACCUM && !i_clear) mem[wr_ptr] <= sample_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sample_q      <= '0;
            wr_ptr        <= '0;
            fill          <= '0;
            sum           <= '0;
            sumsq         <= '0;
            mean_q        <= '0;
            var_q         <= '0;
            bit_cnt       <= '0;
            root          <= '0;
            rem           <= '0;
            o_mean        <= '0;
            o_variance    <= '0;
            o_stddev      <= '0;
            o_window_full <= 1'b0;
`ifdef MOVING_STATS_REMAINDER_EN
            o_sqrt_rem    <= '0;
`endif
        end else if (i_clear) begin
            wr_ptr        <= '0;
            fill          <= '0;
            sum           <= '0;
            sumsq         <= '0;
            o_window_full <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_valid) sample_q <= i_data;
                ACCUM: begin
                    sum    <= sum + SW'(sample_q) - SW'(outgoing);
                    sumsq  <= sumsq + QW'(sample_q) * QW'(sample_q)
                                    - QW'(outgoing) * QW'(outgoing);
                    wr_ptr <= wr_ptr + 1'b1;
                    if (fill != FULL) begin
                        fill <= fill + 1'b1;
                        if (fill == FULL - 1'b1) o_window_full <= 1'b1;
                    end
                end
                VAR: begin
                    mean_q  <= sum[SW-1:L];
                    var_q   <= var_num[VW-1:2*L];
                    bit_cnt <= CW'(DW-1);
                    root    <= '0;
                    rem     <= '0;
                end
                SQRT: begin
                    root    <= {root[DW-2:0], root_bit};
                    rem     <= rem_next[DW:0];
                    bit_cnt <= bit_cnt - 1'b1;
                    // Final root bit lands straight in the result registers so DONE sees it
                    if (bit_cnt == '0) begin
                        o_mean     <= mean_q;
                        o_variance <= var_q;
                        o_stddev   <= {root[DW-2:0], root_bit};
`ifdef MOVING_STATS_REMAINDER_EN
                        o_sqrt_rem <= (2*DW+1)'(rem_next[DW:0]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
